// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream: read-side FIFO consumer with 2-entry prefetch and stream out.
// Optional FIFO_RD_STATS_EN adds rd_words/rd_stalls counters.
module async_fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [DATA_SIZE-1:0] r_data,
  input  logic                 r_empty,
  output logic                 r_inc,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 drain,
  output logic [1:0]           buf_level,
  output logic [ADDR_SIZE:0]   drain_cnt
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]          rd_words,
  output logic [31:0]          rd_stalls
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE:0] CNT_MAX =
    {1'b1, {ADDR_SIZE{1'b0}}};

  state_t               state_q;
  logic [DATA_SIZE-1:0] data0_q;
  logic [DATA_SIZE-1:0] data1_q;
  logic                 valid_q;
  logic [1:0]           level_q;
  logic [ADDR_SIZE:0]   dcnt_q;
  logic                 drain_q;
  logic                 pop;
  logic                 deq;

  // Pop only depends on FIFO flag, own state and drain; never on m_ready.
  assign r_inc = !r_rst && !r_empty && (drain || state_q != ST_TWO);
  assign pop   = r_inc && !drain;
  assign deq   = valid_q && m_ready;

  assign m_data    = data0_q;
  assign m_valid   = valid_q;
  assign buf_level = level_q;
  assign drain_cnt = dcnt_q;

  // Prefetch buffer FSM with drain override and discard counter.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= ST_EMPTY;
      data0_q <= '0;
      data1_q <= '0;
      valid_q <= 1'b0;
      level_q <= 2'd0;
      dcnt_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= drain;
      if (drain) begin
        state_q <= ST_EMPTY;
        valid_q <= 1'b0;
        level_q <= 2'd0;
        if (!drain_q)
          dcnt_q <= (ADDR_SIZE+1)'(r_inc);
        else if (r_inc && dcnt_q != CNT_MAX)
          dcnt_q <= dcnt_q + 1'b1;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (pop) begin
              state_q <= ST_ONE;
              data0_q <= r_data;
              valid_q <= 1'b1;
              level_q <= 2'd1;
            end
          end
          ST_ONE: begin
            if (pop && deq) begin
              data0_q <= r_data;
            end else if (pop) begin
              state_q <= ST_TWO;
              data1_q <= r_data;
              level_q <= 2'd2;
            end else if (deq) begin
              state_q <= ST_EMPTY;
              valid_q <= 1'b0;
              level_q <= 2'd0;
            end
          end
          ST_TWO: begin
            if (deq) begin
              state_q <= ST_ONE;
              data0_q <= data1_q;
              level_q <= 2'd1;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            level_q <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stalls_q;

  assign rd_words  = words_q;
  assign rd_stalls = stalls_q;

  // Handshake and stall counters, frozen while draining.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else if (!drain) begin
      if (deq)
        words_q <= words_q + 32'd1;
      if (valid_q && !m_ready)
        stalls_q <= stalls_q + 32'd1;
    end
  end
`endif

endmodule
